ifetch_queue: RTL and testbench

//  Instruction-fetch front end; consumes the fetch PC side of the pipeline. Owns a sequential fetch

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_slot_ring.sv | 76 +++++++
 rtl/ifetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_pkg;

    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_3000;
    localparam int          INSTR_W      = 32;
    localparam int          ADDR_W       = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } ifq_slot_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_slot_ring.sv
// DEPTH-slot ring of {pc, instr, filled}: allocate at tail, fill oldest unfilled, pop at head.
module ifetch_slot_ring
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               alloc,
    input  logic [ADDR_W-1:0]  alloc_pc,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_data,
    input  logic               pop,
    output ifq_slot_t          head,
    output logic [CW-1:0]      used,
    output logic [CW-1:0]      unfilled
);

    ifq_slot_t     slot_r [DEPTH];
    logic [PW-1:0] head_ptr_r;
    logic [PW-1:0] tail_ptr_r;
    logic [PW-1:0] fill_ptr_r;
    logic [CW-1:0] used_r;
    logic [CW-1:0] unfilled_r;

    // Slot storage; filled is dropped on pop so a stale slot never reappears as a valid head
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                slot_r[tail_ptr_r] <= {alloc_pc, {INSTR_W{1'b0}}, 1'b0};
            end
            if (fill) begin
                slot_r[fill_ptr_r].instr  <= fill_data;
                slot_r[fill_ptr_r].filled <= 1'b1;
            end
            if (pop) begin
                slot_r[head_ptr_r].filled <= 1'b0;
            end
        end
    end

    // Pointers and occupancy counts
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head_ptr_r <= {PW{1'b0}};
            tail_ptr_r <= {PW{1'b0}};
            fill_ptr_r <= {PW{1'b0}};
            used_r     <= {CW{1'b0}};
            unfilled_r <= {CW{1'b0}};
        end else begin
            if (alloc) begin
                tail_ptr_r <= tail_ptr_r + PW'(1);
            end
            if (fill) begin
                fill_ptr_r <= fill_ptr_r + PW'(1);
            end
            if (pop) begin
                head_ptr_r <= head_ptr_r + PW'(1);
            end
            used_r     <= used_r + CW'(alloc) - CW'(pop);
            unfilled_r <= unfilled_r + CW'(alloc) - CW'(fill);
        end
    end

    assign head     = slot_r[head_ptr_r];
    assign used     = used_r;
    assign unfilled = unfilled_r;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch pointer, in-order requests, response ring, redirect flush.
// Define IFETCH_PERF_EN to add the perf_fetch_cnt / perf_redirect_cnt / perf_stall_cnt outputs.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] used_s;
    logic [CW-1:0] unfilled_s;
    logic [CW-1:0] pending_s;
    logic [CW-1:0] redir_drop_s;
    logic [CW:0]   inflight_s;
    ifq_slot_t     head_s;
    logic          ring_empty_s;
    logic          req_fire_s;
    logic          rsp_drop_s;
    logic          fill_s;
    logic          pop_s;

    // Handshake decode; in-flight includes responses still owed for flushed requests
    always_comb begin
        inflight_s     = {1'b0, used_s} + {1'b0, drop_cnt_r};
        ring_empty_s   = (used_s == {CW{1'b0}});
        imem_req_valid = !reset && !redirect_valid && (inflight_s < (CW+1)'(DEPTH));
        req_fire_s     = imem_req_valid && imem_req_ready;
        rsp_drop_s     = imem_rsp_valid && (drop_cnt_r != {CW{1'b0}});
        fill_s         = imem_rsp_valid && !reset && !redirect_valid
                         && (drop_cnt_r == {CW{1'b0}}) && (unfilled_s != {CW{1'b0}});
        dec_valid      = !reset && !redirect_valid && !ring_empty_s && head_s.filled;
        pop_s          = dec_valid && dec_ready;
        pending_s      = drop_cnt_r + unfilled_s;
        if (imem_rsp_valid && (pending_s != {CW{1'b0}})) begin
            redir_drop_s = pending_s - CW'(1);
        end else begin
            redir_drop_s = pending_s;
        end
        if (ring_empty_s) begin
            dec_pc    = 32'h0000_0000;
            dec_instr = 32'h0000_0000;
        end else begin
            dec_pc    = head_s.pc;
            dec_instr = head_s.instr;
        end
    end

    assign imem_req_addr = fetch_pc_r;

    // Fetch pointer and stale-response accounting; a redirect overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            drop_cnt_r <= {CW{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r <= word_align(redirect_pc);
            drop_cnt_r <= redir_drop_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (rsp_drop_s) begin
                drop_cnt_r <= drop_cnt_r - CW'(1);
            end
        end
    end

    ifetch_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .alloc     (req_fire_s),
        .alloc_pc  (fetch_pc_r),
        .fill      (fill_s),
        .fill_data (imem_rsp_data),
        .pop       (pop_s),
        .head      (head_s),
        .used      (used_s),
        .unfilled  (unfilled_s)
    );

`ifdef IFETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt    <= 32'd0;
            perf_redirect_cnt <= 32'd0;
            perf_stall_cnt    <= 32'd0;
        end else begin
            if (req_fire_s) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
            if (dec_ready && !dec_valid) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order, holdable 1-cycle instruction memory.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_n, first_acc, first_dec, max_pend, n_acc_total;
    logic        mem_hold = 1'b0;
    logic [31:0] pend_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_instr_q[$];

    ifetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
    endtask

    // One clock cycle: drive memory response, sample handshakes mid-cycle, step past the edge
    task automatic cyc();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!mem_hold && pend_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q.pop_front());
        end
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            acc_q.push_back(imem_req_addr);
            pend_q.push_back(imem_req_addr);
            n_acc_total++;
            if (first_acc < 0) first_acc = cyc_n;
        end
        if (pend_q.size() > max_pend) max_pend = pend_q.size();
        if (dec_valid && first_dec < 0) first_dec = cyc_n;
        if (dec_valid && dec_ready) begin
            pop_pc_q.push_back(dec_pc);
            pop_instr_q.push_back(dec_instr);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        mem_hold       = 1'b0;
        pend_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_dec_valid", 32'(dec_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        cyc_n = 0; first_acc = -1; first_dec = -1; n_acc_total = 0;
        #1;
        check_val("rst_addr", imem_req_addr, 32'h0000_3000);
        check_val("rst_dec_pc", dec_pc, 32'h0);
        check_val("rst_dec_instr", dec_instr, 32'h0);
    endtask

    initial begin
        max_pend = 0;

        // 1: streaming fetch with 1-cycle memory
        do_reset();
        repeat (8) cyc();
        for (int i = 0; i < 4; i++) begin
            check_val("t1_addr", qget(acc_q, i), 32'h3000 + 32'(4 * i));
            check_val("t1_pop_pc", qget(pop_pc_q, i), 32'h3000 + 32'(4 * i));
            check_val("t1_pop_instr", qget(pop_instr_q, i), mem_word(32'h3000 + 32'(4 * i)));
        end
        check_val("t1_latency", 32'(first_dec - first_acc), 32'd2);

        // 2: decode stalled fills the ring, then drains in order
        do_reset();
        dec_ready = 1'b0;
        repeat (8) cyc();
        check_val("t2_accepts", 32'(acc_q.size()), 32'd4);
        check_val("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
        check_val("t2_head_valid", 32'(dec_valid), 32'd1);
        check_val("t2_head_pc", dec_pc, 32'h3000);
        dec_ready = 1'b1;
        clear_logs();
        repeat (8) cyc();
        for (int i = 0; i < 4; i++) begin
            check_val("t2_pop_pc", qget(pop_pc_q, i), 32'h3000 + 32'(4 * i));
        end
        check_val("t2_resume_addr", qget(acc_q, 0), 32'h3010);

        // 3: redirect with 3 in flight (memory held), stale responses discarded
        do_reset();
        mem_hold = 1'b1;
        repeat (3) cyc();
        check_val("t3_inflight", 32'(acc_q.size()), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4001;
        #1;
        check_val("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("t3_redir_dec_valid", 32'(dec_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        clear_logs();
        #1;
        check_val("t3_new_addr", imem_req_addr, 32'h0000_4000);
        repeat (10) cyc();
        check_val("t3_addr0", qget(acc_q, 0), 32'h4000);
        check_val("t3_addr1", qget(acc_q, 1), 32'h4004);
        check_val("t3_pop_pc0", qget(pop_pc_q, 0), 32'h4000);
        check_val("t3_pop_instr0", qget(pop_instr_q, 0), mem_word(32'h4000));
        check_val("t3_pop_pc1", qget(pop_pc_q, 1), 32'h4004);
`ifdef IFETCH_PERF_EN
        check_val("t6_perf_redirect", perf_redirect_cnt, 32'd1);
        check_val("t6_perf_fetch", perf_fetch_cnt, 32'(n_acc_total));
`endif

        // 4: redirect coincides with a stale response, 2 in flight
        do_reset();
        mem_hold = 1'b1;
        repeat (2) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5000;
        mem_hold       = 1'b0;
        cyc();
        redirect_valid = 1'b0;
        clear_logs();
        repeat (6) cyc();
        check_val("t4_addr0", qget(acc_q, 0), 32'h5000);
        check_val("t4_pop_pc0", qget(pop_pc_q, 0), 32'h5000);
        check_val("t4_pop_instr0", qget(pop_instr_q, 0), mem_word(32'h5000));

        // back-to-back redirects: last target wins, drop count accumulates
        do_reset();
        mem_hold = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_6000;
        cyc();
        redirect_pc    = 32'h0000_7002;
        cyc();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        clear_logs();
        repeat (6) cyc();
        check_val("b2b_addr0", qget(acc_q, 0), 32'h7000);
        check_val("b2b_pop_pc0", qget(pop_pc_q, 0), 32'h7000);
        check_val("b2b_pop_instr0", qget(pop_instr_q, 0), mem_word(32'h7000));

        // stale responses owed still occupy in-flight budget
        do_reset();
        mem_hold = 1'b1;
        repeat (3) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_8000;
        cyc();
        redirect_valid = 1'b0;
        clear_logs();
        repeat (4) cyc();
        check_val("drop_budget_accepts", 32'(acc_q.size()), 32'd1);

        // 5: fetch pointer wraps at the top of the address space
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cyc();
        redirect_valid = 1'b0;
        clear_logs();
        repeat (6) cyc();
        check_val("t5_addr0", qget(acc_q, 0), 32'hFFFF_FFF8);
        check_val("t5_addr1", qget(acc_q, 1), 32'hFFFF_FFFC);
        check_val("t5_addr2", qget(acc_q, 2), 32'h0000_0000);
        check_val("t5_pop_pc2", qget(pop_pc_q, 2), 32'h0000_0000);

        check_val("max_inflight_le_depth", 32'(max_pend <= 4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
